// File: rtl/pixel_point_reader_if.sv
// pixel_point_reader_if
//   Bundles the two handshakes of the point reader.
//   Point side  : pt_req, coordinate_x/y in; Ans_valid, pt_pixl_value, range_err out.
//   Memory side : rd_req, rd_addr out; rd_ack, rd_valid, rd_data in.
//   modport slave  : the reader itself.
//   modport master : the environment (requester plus frame buffer).
`timescale 1ns/1ps
interface pixel_point_reader_if #(
   parameter int ADDR_W = 19
);
   logic              pt_req;
   logic [9:0]        coordinate_x;
   logic [9:0]        coordinate_y;
   logic              Ans_valid;
   logic              pt_pixl_value;
   logic              range_err;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic              rd_valid;
   logic [7:0]        rd_data;

   modport slave (
      input  pt_req, coordinate_x, coordinate_y, rd_ack, rd_valid, rd_data,
      output Ans_valid, pt_pixl_value, range_err, rd_req, rd_addr
   );

   modport master (
      output pt_req, coordinate_x, coordinate_y, rd_ack, rd_valid, rd_data,
      input  Ans_valid, pt_pixl_value, range_err, rd_req, rd_addr
   );
endinterface

// File: rtl/pixel_point_reader.sv
// pixel_point_reader
//   Reads one gray pixel at (x, y) from a frame buffer and answers whether
//   it is black (gray < THRESH). Out-of-image points answer 0 with range_err
//   and never touch memory.
// Ports
//   clk, rst    : single clock, asynchronous active-high reset
//   bus (slave) : point request/answer and frame-buffer read handshake
//   timeout_err : only with PIXEL_READ_TIMEOUT_EN; pulses with Ans_valid when
//                 the read was abandoned after TIMEOUT cycles
// Configuration
//   PIXEL_READ_TIMEOUT_EN : adds the read watchdog and the timeout_err port.
`timescale 1ns/1ps
module pixel_point_reader #(
   parameter int         IMG_W   = 640,
   parameter int         IMG_H   = 480,
   parameter logic [7:0] THRESH  = 8'd128,
   parameter int         ADDR_W  = 19,
   parameter int         TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   pixel_point_reader_if.slave bus
`ifdef PIXEL_READ_TIMEOUT_EN
  ,output logic                timeout_err
`endif
);

   typedef enum logic [5:0] {
      IDLE = 6'b000001,
      ADDR = 6'b000010,
      REQ  = 6'b000100,
      WAIT = 6'b001000,
      RESP = 6'b010000,
      HOLD = 6'b100000
   } state_e;

   state_e            state_q, state_d;
   logic [9:0]        x_q, x_d;
   logic [9:0]        y_q, y_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_req_q, rd_req_d;
   logic              pix_q, pix_d;       // captured answer, published in RESP
   logic              oor_q, oor_d;       // answer comes from a range failure
   logic              ans_q, ans_d;
   logic              pixl_q, pixl_d;
   logic              range_err_q, range_err_d;
   // Read data is registered once before use; this stage is part of the
   // answer latency and also decouples rd_valid from the next-state logic.
   logic              rd_valid_q, rd_valid_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              in_range;

`ifdef PIXEL_READ_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;          // answer comes from the watchdog
   logic             timeout_err_q, timeout_err_d;
   logic             expire;

   // The counter reaches TIMEOUT on the edge that takes the FSM to RESP.
   assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   assign in_range   = (32'(x_q) < 32'(IMG_W)) && (32'(y_q) < 32'(IMG_H));
   assign rd_valid_d = bus.rd_valid;
   assign rd_data_d  = bus.rd_data;

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      rd_addr_d     = rd_addr_q;
      pix_d         = pix_q;
      oor_d         = oor_q;
      ans_d         = 1'b0;
      pixl_d        = pixl_q;
      range_err_d   = 1'b0;
`ifdef PIXEL_READ_TIMEOUT_EN
      cnt_d         = cnt_q;
      to_d          = to_q;
      timeout_err_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.pt_req) begin
               x_d     = bus.coordinate_x;
               y_d     = bus.coordinate_y;
               state_d = ADDR;
            end
         end
         ADDR: begin
            // Full-precision linear address, truncated to the bus width.
            rd_addr_d = ADDR_W'(32'(y_q) * 32'(IMG_W) + 32'(x_q));
            pix_d     = 1'b0;
            oor_d     = !in_range;
`ifdef PIXEL_READ_TIMEOUT_EN
            to_d      = 1'b0;
            cnt_d     = '0;
`endif
            state_d   = in_range ? REQ : RESP;
         end
         REQ: begin
`ifdef PIXEL_READ_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            // A same-cycle rd_valid is held in rd_valid_q and consumed in WAIT.
            if (bus.rd_ack) begin
               state_d = WAIT;
            end
`ifdef PIXEL_READ_TIMEOUT_EN
            else if (expire) begin
               to_d    = 1'b1;
               state_d = RESP;
            end
`endif
         end
         WAIT: begin
`ifdef PIXEL_READ_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (rd_valid_q) begin
               pix_d   = (rd_data_q < THRESH);
               state_d = RESP;
            end
`ifdef PIXEL_READ_TIMEOUT_EN
            else if (expire) begin
               to_d    = 1'b1;
               state_d = RESP;
            end
`endif
         end
         RESP: begin
            ans_d         = 1'b1;
            pixl_d        = pix_q;
            range_err_d   = oor_q;
`ifdef PIXEL_READ_TIMEOUT_EN
            timeout_err_d = to_q;
`endif
            state_d       = HOLD;
         end
         HOLD: begin
            // The answered request is still high here; wait for it to drop.
            if (!bus.pt_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rd_req_d = (state_d == REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         rd_addr_q     <= '0;
         rd_req_q      <= 1'b0;
         pix_q         <= 1'b0;
         oor_q         <= 1'b0;
         ans_q         <= 1'b0;
         pixl_q        <= 1'b0;
         range_err_q   <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_data_q     <= '0;
`ifdef PIXEL_READ_TIMEOUT_EN
         cnt_q         <= '0;
         to_q          <= 1'b0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         rd_addr_q     <= rd_addr_d;
         rd_req_q      <= rd_req_d;
         pix_q         <= pix_d;
         oor_q         <= oor_d;
         ans_q         <= ans_d;
         pixl_q        <= pixl_d;
         range_err_q   <= range_err_d;
         rd_valid_q    <= rd_valid_d;
         rd_data_q     <= rd_data_d;
`ifdef PIXEL_READ_TIMEOUT_EN
         cnt_q         <= cnt_d;
         to_q          <= to_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   assign bus.rd_req        = rd_req_q;
   assign bus.rd_addr       = rd_addr_q;
   assign bus.Ans_valid     = ans_q;
   assign bus.pt_pixl_value = pixl_q;
   assign bus.range_err     = range_err_q;
`ifdef PIXEL_READ_TIMEOUT_EN
   assign timeout_err       = timeout_err_q;
`endif

endmodule

// File: doc/pixel_point_reader.md
PIXEL_POINT_READER -- requirements
Module: pixel_point_reader

Interface
REQ-001 Parameter IMG_W, default 640, image width in pixels; also the row stride for the address.
REQ-002 Parameter IMG_H, default 480, image height in pixels.
REQ-003 Parameter THRESH, default 8'd128, gray level below which a pixel counts as black.
REQ-004 Parameter ADDR_W, default 19, frame-buffer word-address width.
REQ-005 Parameter TIMEOUT, default 255, maximum cycles to wait for rd_valid (used only with the timeout feature).
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 pt_req  in  1  point request level; held high by the requester until it sees Ans_valid.
REQ-009 coordinate_x  in  10  point x; stable while pt_req is high.
REQ-010 coordinate_y  in  10  point y; stable while pt_req is high.
REQ-011 Ans_valid  out  1  one-cycle high pulse; the answer is ready.
REQ-012 pt_pixl_value  out  1  binarised pixel, 1 = black; valid with Ans_valid and held until the next answer.
REQ-013 rd_req  out  1  frame-buffer read request level.
REQ-014 rd_addr  out  ADDR_W  frame-buffer word address.
REQ-015 rd_ack  in  1  read request accepted this cycle.
REQ-016 rd_valid  in  1  rd_data valid this cycle (one-cycle pulse).
REQ-017 rd_data  in  8  gray pixel value.
REQ-018 range_err  out  1  one-cycle pulse; the requested point was outside the image.

Function
REQ-019 The FSM SHALL have the states IDLE, ADDR, REQ, WAIT, RESP and HOLD, one-hot encoded.
REQ-020 IDLE -> ADDR when pt_req=1; coordinate_x and coordinate_y are captured on that edge.
REQ-021 ADDR, address and range:
- rd_addr <= y*IMG_W + x, computed at full precision then truncated to ADDR_W bits.
- In range: -> REQ.
- x >= IMG_W or y >= IMG_H: -> RESP with pixel forced to 0 and range_err pulsed; no memory read is issued.
REQ-022 REQ: rd_req=1 with rd_addr stable; -> WAIT on the cycle rd_ack=1. rd_req SHALL drop on the cycle after rd_ack.
REQ-023 WAIT: on rd_valid=1, capture pixel = (rd_data < THRESH) and -> RESP; rd_valid seen in any other state SHALL be ignored.
REQ-024 RESP: Ans_valid=1 for exactly one cycle, pt_pixl_value updated on the same edge; -> HOLD.
REQ-025 HOLD: -> IDLE once pt_req=0. A pt_req still high from the answered request SHALL NOT start a second read.
REQ-026 Latency: with rd_ack in the first REQ cycle and rd_valid N cycles later, Ans_valid SHALL be high N+4 cycles after pt_req is first sampled high.
REQ-027 Out-of-range latency: Ans_valid SHALL be high 2 cycles after pt_req is first sampled high.
REQ-028 At most one read SHALL be outstanding at a time.
REQ-029 rd_ack arriving in the same cycle as rd_valid for the same request is legal and SHALL complete the read (REQ -> RESP).

Reset
REQ-030 With rst=1, regardless of clk:
- state = IDLE
- Ans_valid = 0, pt_pixl_value = 0, rd_req = 0, rd_addr = 0, range_err = 0
- timeout_err = 0 (when the timeout feature is compiled in)
REQ-031 rst asserted mid-read SHALL abandon the read; a late rd_valid after reset release SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-032 Macro PIXEL_READ_TIMEOUT_EN, when defined:
- adds output timeout_err (1 bit, one-cycle pulse);
- adds a counter that clears on entry to REQ and increments in REQ and WAIT;
- when the counter reaches TIMEOUT, the FSM SHALL go -> RESP with pixel 0 and pulse timeout_err.
REQ-033 When PIXEL_READ_TIMEOUT_EN is undefined: no timeout_err port and no counter; REQ and WAIT wait indefinitely.

Verification
REQ-034 x=100, y=2, rd_ack immediate, rd_valid 3 cycles later with rd_data=8'd40 -> rd_addr=1380; Ans_valid pulse 7 cycles after pt_req; pt_pixl_value=1.
REQ-035 Same request with rd_data=8'd200 -> pt_pixl_value=0; rd_data=8'd128 -> 0 (threshold boundary).
REQ-036 x=640, y=0 -> rd_req stays 0; range_err and Ans_valid pulse 2 cycles after pt_req; pt_pixl_value=0.
REQ-037 pt_req held high 5 cycles past Ans_valid -> exactly one rd_req transaction and one Ans_valid.
REQ-038 rst pulsed while in WAIT, then rd_valid arrives -> no Ans_valid; all outputs at reset values.
REQ-039 With PIXEL_READ_TIMEOUT_EN and rd_valid never arriving -> timeout_err and Ans_valid pulse with pt_pixl_value=0, 256 cycles after REQ entry.
